// File: rtl/lottery_checker_if.sv
// Player/key-side signals of the lottery checker: button and digit inputs toward the
// engine, and display/result outputs toward the 7-segment decoders and win LED.
interface lottery_checker_if #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W    = 4
);
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int PRIZE_W = $clog2(NUM_DIGITS + 2);

  logic [DIGIT_W-1:0]            digit_in;
  logic                          insert;
  logic                          undo;
  logic                          finish;
  logic                          key_load;
  logic [NUM_DIGITS*DIGIT_W-1:0] key_in;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_out;
  logic [NUM_DIGITS-1:0]         digit_valid;
  logic [CNT_W-1:0]              entry_count;
  logic                          reject;
  logic                          result_valid;
  logic [CNT_W-1:0]              match_count;
  logic [PRIZE_W-1:0]            prize;
  logic                          win;
  logic [7:0]                    games_played;

  modport master (
    output digit_in, insert, undo, finish, key_load, key_in,
    input  digits_out, digit_valid, entry_count, reject, result_valid,
           match_count, prize, win, games_played
  );

  modport slave (
    input  digit_in, insert, undo, finish, key_load, key_in,
    output digits_out, digit_valid, entry_count, reject, result_valid,
           match_count, prize, win, games_played
  );
endinterface

// File: rtl/lottery_checker.sv
// Lottery ticket entry/check engine: digit entry with undo, positional match count
// against a reloadable key, and prize tier grading.
//
// state  | meaning
// ENTRY  | collecting digits; undo allowed; finish ignored
// READY  | ticket full; insert rejected; undo reopens entry; finish submits
// CHECK  | one cycle: count matches, grade prize, bump games_played
// RESULT | outputs held until finish starts a new game
module lottery_checker #(
  parameter int                            NUM_DIGITS = 5,
  parameter int                            DIGIT_W    = 4,
  parameter int                            MAX_DIGIT  = 9,
  parameter int                            MIN_MATCH  = 3,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] WIN_KEY    = 20'h50967
) (
  input logic              clk,
  input logic              reset,
  lottery_checker_if.slave bus
);
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int PRIZE_W = $clog2(NUM_DIGITS + 2);
  localparam int VEC_W   = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {ENTRY, READY, CHECK, RESULT} state_t;

  state_t             state;
  logic [VEC_W-1:0]   digits;
  logic [NUM_DIGITS-1:0] valid;
  logic [CNT_W-1:0]   count;
  logic [VEC_W-1:0]   key;
  logic               reject;
  logic               result_valid;
  logic [CNT_W-1:0]   match_count;
  logic [PRIZE_W-1:0] prize;
  logic               win;
  logic [7:0]         games;
  logic               insert_q, undo_q, finish_q;

  logic               ev_finish, ev_undo, ev_insert;
  logic [VEC_W-1:0]   digits_ins, digits_undo;
  logic [NUM_DIGITS-1:0] valid_ins, valid_undo;
  logic [CNT_W-1:0]   match_calc;
  logic [PRIZE_W-1:0] prize_calc;

  // finish outranks undo, which outranks insert; losers in the same cycle are dropped
  assign ev_finish = bus.finish & ~finish_q;
  assign ev_undo   = bus.undo & ~undo_q & ~ev_finish;
  assign ev_insert = bus.insert & ~insert_q & ~ev_finish & ~(bus.undo & ~undo_q);

  // Slot for digit number c lives at slice NUM_DIGITS-1-c (first digit in the MS slice)
  always_comb begin
    digits_ins  = digits;
    digits_undo = digits;
    valid_ins   = valid;
    valid_undo  = valid;
    match_calc  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CNT_W'(NUM_DIGITS - 1 - i) == count) begin
        digits_ins[i*DIGIT_W +: DIGIT_W] = bus.digit_in;
        valid_ins[i] = 1'b1;
      end
      if (CNT_W'(NUM_DIGITS - i) == count) begin
        digits_undo[i*DIGIT_W +: DIGIT_W] = '0;
        valid_undo[i] = 1'b0;
      end
      if (digits[i*DIGIT_W +: DIGIT_W] == key[i*DIGIT_W +: DIGIT_W])
        match_calc = match_calc + CNT_W'(1);
    end
  end

  assign prize_calc = (match_calc >= CNT_W'(MIN_MATCH))
                    ? PRIZE_W'(NUM_DIGITS + 1) - PRIZE_W'(match_calc)
                    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ENTRY;
      digits       <= '0;
      valid        <= '0;
      count        <= '0;
      key          <= WIN_KEY;
      reject       <= 1'b0;
      result_valid <= 1'b0;
      match_count  <= '0;
      prize        <= '0;
      win          <= 1'b0;
      games        <= '0;
      insert_q     <= 1'b0;
      undo_q       <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      insert_q <= bus.insert;
      undo_q   <= bus.undo;
      finish_q <= bus.finish;
      reject   <= 1'b0;

      // key may only change between tickets
      if (bus.key_load && state == ENTRY && count == '0)
        key <= bus.key_in;

      case (state)
        ENTRY: begin
          if (ev_undo) begin
            if (count != '0) begin
              digits <= digits_undo;
              valid  <= valid_undo;
              count  <= count - CNT_W'(1);
            end
          end else if (ev_insert) begin
            if (bus.digit_in > DIGIT_W'(MAX_DIGIT) || count >= CNT_W'(NUM_DIGITS)) begin
              reject <= 1'b1;
            end else begin
              digits <= digits_ins;
              valid  <= valid_ins;
              count  <= count + CNT_W'(1);
              if (count == CNT_W'(NUM_DIGITS - 1))
                state <= READY;
            end
          end
        end
        READY: begin
          if (ev_finish) begin
            state <= CHECK;
          end else if (ev_undo) begin
            digits <= digits_undo;
            valid  <= valid_undo;
            count  <= count - CNT_W'(1);
            state  <= ENTRY;
          end else if (ev_insert) begin
            reject <= 1'b1;
          end
        end
        CHECK: begin
          match_count  <= match_calc;
          prize        <= prize_calc;
          win          <= (prize_calc != '0);
          result_valid <= 1'b1;
          games        <= games + 8'd1;
          state        <= RESULT;
        end
        RESULT: begin
          if (ev_finish) begin
            digits       <= '0;
            valid        <= '0;
            count        <= '0;
            result_valid <= 1'b0;
            match_count  <= '0;
            prize        <= '0;
            win          <= 1'b0;
            state        <= ENTRY;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign bus.digits_out   = digits;
  assign bus.digit_valid  = valid;
  assign bus.entry_count  = count;
  assign bus.reject       = reject;
  assign bus.result_valid = result_valid;
  assign bus.match_count  = match_count;
  assign bus.prize        = prize;
  assign bus.win          = win;
  assign bus.games_played = games;
endmodule

// File: tb/tb_lottery_checker.sv
// Directed bench for lottery_checker: entry, undo, reject, grading, key reload and reset.
module tb_lottery_checker;
  logic clk;
  logic reset;
  int   total  = 0;
  int   passes = 0;

  lottery_checker_if #(.NUM_DIGITS(5), .DIGIT_W(4)) bus ();

  lottery_checker #(
    .NUM_DIGITS(5), .DIGIT_W(4), .MAX_DIGIT(9), .MIN_MATCH(3), .WIN_KEY(20'h50967)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press_insert(input logic [3:0] d);
    bus.digit_in = d;
    bus.insert   = 1'b1;
    tick();
    bus.insert   = 1'b0;
    tick();
  endtask

  task automatic press_undo();
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    tick();
  endtask

  task automatic press_finish();
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    tick();
  endtask

  task automatic enter_ticket(input logic [19:0] t);
    for (int i = 4; i >= 0; i--) press_insert(t[i*4 +: 4]);
  endtask

  task automatic check_result(input string tag, input logic [2:0] m, input logic [2:0] p,
                              input logic w, input logic [7:0] g);
    chk({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_match"}, 32'(bus.match_count), 32'(m));
    chk({tag, "_prize"}, 32'(bus.prize), 32'(p));
    chk({tag, "_win"},   32'(bus.win), 32'(w));
    chk({tag, "_games"}, 32'(bus.games_played), 32'(g));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rv"},     32'(bus.result_valid), 32'd0);
    chk({tag, "_count"},  32'(bus.entry_count), 32'd0);
    chk({tag, "_digits"}, 32'(bus.digits_out), 32'd0);
    chk({tag, "_dvalid"}, 32'(bus.digit_valid), 32'd0);
    chk({tag, "_prize"},  32'(bus.prize), 32'd0);
    chk({tag, "_win"},    32'(bus.win), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    bus.digit_in = '0;
    bus.insert   = 1'b0;
    bus.undo     = 1'b0;
    bus.finish   = 1'b0;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    #22;
    check_cleared("reset");
    chk("reset_reject", 32'(bus.reject), 32'd0);
    chk("reset_match",  32'(bus.match_count), 32'd0);
    chk("reset_games",  32'(bus.games_played), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // full match, with latency check
    enter_ticket(20'h50967);
    chk("full_digits", 32'(bus.digits_out), 32'h50967);
    chk("full_dvalid", 32'(bus.digit_valid), 32'h1f);
    chk("full_count",  32'(bus.entry_count), 32'd5);
    bus.finish = 1'b1;
    tick();
    chk("lat_check_cycle", 32'(bus.result_valid), 32'd0);
    bus.finish = 1'b0;
    tick();
    check_result("g1", 3'd5, 3'd1, 1'b1, 8'd1);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    tick();
    chk("result_undo_ign", 32'(bus.entry_count), 32'd5);
    press_finish();
    check_cleared("newgame");
    chk("newgame_games", 32'(bus.games_played), 32'd1);

    enter_ticket(20'h50961);
    press_finish();
    check_result("g2", 3'd4, 3'd2, 1'b1, 8'd2);
    press_finish();
    enter_ticket(20'h50007);
    press_finish();
    check_result("g3", 3'd3, 3'd3, 1'b1, 8'd3);
    press_finish();
    enter_ticket(20'h12345);
    press_finish();
    check_result("g4", 3'd0, 3'd0, 1'b0, 8'd4);
    press_finish();

    // out-of-range digit and undo past empty
    press_insert(4'd5);
    press_insert(4'd0);
    bus.digit_in = 4'd12;
    bus.insert   = 1'b1;
    tick();
    chk("bad_reject", 32'(bus.reject), 32'd1);
    chk("bad_count",  32'(bus.entry_count), 32'd2);
    bus.insert = 1'b0;
    tick();
    chk("bad_reject_end", 32'(bus.reject), 32'd0);
    press_undo();
    chk("undo1_digits", 32'(bus.digits_out), 32'h50000);
    press_undo();
    bus.undo = 1'b1;
    tick();
    chk("undo_empty_reject", 32'(bus.reject), 32'd0);
    bus.undo = 1'b0;
    tick();
    chk("undo_empty_count",  32'(bus.entry_count), 32'd0);
    chk("undo_empty_digits", 32'(bus.digits_out), 32'd0);

    // full ticket: insert rejected, undo reopens entry, finish in ENTRY ignored
    enter_ticket(20'h50961);
    bus.digit_in = 4'd3;
    bus.insert   = 1'b1;
    tick();
    chk("full_reject", 32'(bus.reject), 32'd1);
    chk("full_keep",   32'(bus.digits_out), 32'h50961);
    bus.insert = 1'b0;
    tick();
    press_undo();
    chk("reopen_count",  32'(bus.entry_count), 32'd4);
    chk("reopen_digits", 32'(bus.digits_out), 32'h50960);
    chk("reopen_dvalid", 32'(bus.digit_valid), 32'h1e);
    press_finish();
    tick();
    chk("entry_fin_rv",    32'(bus.result_valid), 32'd0);
    chk("entry_fin_count", 32'(bus.entry_count), 32'd4);
    chk("entry_fin_games", 32'(bus.games_played), 32'd4);
    for (int i = 0; i < 4; i++) press_undo();
    chk("cleared_count", 32'(bus.entry_count), 32'd0);

    // key reload while idle
    bus.key_in   = 20'h12345;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    enter_ticket(20'h12345);
    press_finish();
    check_result("newkey", 3'd5, 3'd1, 1'b1, 8'd5);
    press_finish();

    // key reload mid-ticket is ignored
    press_insert(4'd9);
    press_insert(4'd9);
    bus.key_in   = 20'h99999;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    for (int i = 0; i < 3; i++) press_insert(4'd9);
    press_finish();
    check_result("midkey", 3'd0, 3'd0, 1'b0, 8'd6);
    press_finish();

    // held insert stores exactly one digit
    bus.digit_in = 4'd4;
    bus.insert   = 1'b1;
    repeat (10) tick();
    bus.insert = 1'b0;
    tick();
    chk("hold_count",  32'(bus.entry_count), 32'd1);
    chk("hold_digits", 32'(bus.digits_out), 32'h40000);

    // async reset mid-result restores default key
    for (int i = 1; i <= 4; i++) press_insert(4'(i));
    press_finish();
    chk("pre_reset_rv", 32'(bus.result_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("async_rst");
    chk("async_rst_games", 32'(bus.games_played), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    enter_ticket(20'h50967);
    press_finish();
    check_result("keyrst", 3'd5, 3'd1, 1'b1, 8'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
